seg7_scan_decoder: RTL and testbench

//  Receiving end of the 4-digit multiplexed 7-segment display bus (dig_sel/segs).

---
 rtl/seg7_scan_decoder_pkg.sv | 42 ++++
 rtl/seg7_scan_decoder_if.sv | 8 +
 rtl/seg7_scan_decoder_seg7_to_bcd.sv | 31 +++
 rtl/seg7_scan_decoder.sv | 173 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_decoder_pkg.sv
// Shared definitions for the 7-segment scan decoder: active-high segment patterns,
// slot indices and the slot-tracking FSM encoding.
package seg7_scan_decoder_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [1:0] SLOT_HH = 2'd0;
  localparam logic [1:0] SLOT_H  = 2'd1;
  localparam logic [1:0] SLOT_MM = 2'd2;
  localparam logic [1:0] SLOT_M  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_CAPTURE,
    ST_HOLD
  } slot_state_e;

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Only meaningful for one-hot inputs; the FSM never captures anything else.
  function automatic logic [1:0] slot_of(input logic [3:0] v);
    logic [1:0] s;
    s = SLOT_HH;
    if (v[1]) s = SLOT_H;
    if (v[2]) s = SLOT_MM;
    if (v[3]) s = SLOT_M;
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed 7-segment display bus: one-hot digit strobes plus active-low segment lines.
interface seg7_scan_decoder_if;
  logic [3:0] dig_sel;
  logic [6:0] segs;

  modport master (output dig_sel, output segs);
  modport slave  (input  dig_sel, input  segs);
endinterface

// File: rtl/seg7_scan_decoder_seg7_to_bcd.sv
// Inverse of the display driver's BCD-to-segment table: active-high {g..a} pattern to
// {valid, value}; unknown patterns decode to 4'hF with valid low.
module seg7_to_bcd
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] value_o
);

  always_comb begin
    valid_o = 1'b1;
    unique case (seg_i)
      SEG_0:   value_o = 4'd0;
      SEG_1:   value_o = 4'd1;
      SEG_2:   value_o = 4'd2;
      SEG_3:   value_o = 4'd3;
      SEG_4:   value_o = 4'd4;
      SEG_5:   value_o = 4'd5;
      SEG_6:   value_o = 4'd6;
      SEG_7:   value_o = 4'd7;
      SEG_8:   value_o = 4'd8;
      SEG_9:   value_o = 4'd9;
      default: begin
        value_o = 4'hF;
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receives the scanned 4-digit display bus, debounces each strobe, decodes the digits
// and publishes complete HH:MM frames with error and loss-of-signal flags.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_decoder_if.slave  disp,
  output logic [1:0]          dig_hh_o,
  output logic [3:0]          dig_h_o,
  output logic [2:0]          dig_mm_o,
  output logic [3:0]          dig_m_o,
  output logic                hh_blank_o,
  output logic                frame_valid_o,
  output logic                seg_error_o,
  output logic                lost_o
);

  localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [2:0] STABLE_W = 3'(STABLE_CYCLES);

  logic [3:0] sel_m_q, sel_s_q;
  logic [6:0] seg_m_q, seg_s_q;
  slot_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] smp_sel_q, smp_sel_d;
  logic [6:0] smp_seg_q, smp_seg_d;
  logic [1:0] hh_sh_q, hh_sh_d;
  logic [3:0] h_sh_q, h_sh_d;
  logic [2:0] mm_sh_q, mm_sh_d;
  logic [3:0] m_sh_q, m_sh_d;
  logic [3:0] mask_q, mask_d;
  logic       err_q, err_d;
  logic [TW-1:0] to_q, to_d;
  logic       lost_q, lost_d;
  logic       pend_q, pend_d, pend_blank_q, pend_blank_d;
  logic [1:0] dig_hh_q, dig_hh_d;
  logic [3:0] dig_h_q, dig_h_d;
  logic [2:0] dig_mm_q, dig_mm_d;
  logic [3:0] dig_m_q, dig_m_d;
  logic       blank_q, blank_d, fv_q, fv_d;

  logic       dec_valid, one_hot, same, start;
  logic [3:0] dec_value;
  logic [2:0] cnt_inc;
  logic [1:0] cap_slot;

  seg7_to_bcd u_dec (
    .seg_i   (~smp_seg_q),
    .valid_o (dec_valid),
    .value_o (dec_value)
  );

  assign one_hot  = is_one_hot(sel_s_q);
  assign same     = (sel_s_q == smp_sel_q) && (seg_s_q == smp_seg_q);
  assign cnt_inc  = cnt_q + 3'd1;
  assign cap_slot = slot_of(smp_sel_q);

  // NOTE: every _d gets its hold value first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;
    smp_sel_d = smp_sel_q;  smp_seg_d = smp_seg_q;
    hh_sh_d = hh_sh_q;  h_sh_d = h_sh_q;  mm_sh_d = mm_sh_q;  m_sh_d = m_sh_q;
    mask_d = mask_q;  err_d = err_q;  to_d = to_q;  lost_d = lost_q;
    pend_d = 1'b0;  pend_blank_d = pend_blank_q;
    dig_hh_d = dig_hh_q;  dig_h_d = dig_h_q;  dig_mm_d = dig_mm_q;  dig_m_d = dig_m_q;
    blank_d = blank_q;  fv_d = 1'b0;
    start = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (one_hot) begin
          start = 1'b1;
        end else if (sel_s_q == 4'd0 && to_q != TO_MAX) begin
          to_d = to_q + TW'(1);
          if (to_d == TO_MAX) lost_d = 1'b1;
        end
      end
      ST_TRACK: begin
        if (!one_hot) begin
          state_d = ST_IDLE;
        end else if (same) begin
          cnt_d = cnt_inc;
          if (cnt_inc == STABLE_W) state_d = ST_CAPTURE;
        end else begin
          start = 1'b1;
        end
      end
      ST_CAPTURE: begin
        unique case (cap_slot)
          SLOT_HH: begin
            hh_sh_d = dec_value[1:0];
            if (dec_value > 4'd2) err_d = 1'b1;
          end
          SLOT_H:  h_sh_d = dec_value;
          SLOT_MM: begin
            mm_sh_d = dec_value[2:0];
            if (dec_value > 4'd5) err_d = 1'b1;
          end
          SLOT_M:  m_sh_d = dec_value;
        endcase
        if (!dec_valid) err_d = 1'b1;
        mask_d[cap_slot] = 1'b1;
        to_d   = '0;
        lost_d = 1'b0;
        // The minute-units digit closes a frame; publish only if slots 1..3 all landed.
        if (cap_slot == SLOT_M) begin
          pend_d       = &mask_q[2:1];
          pend_blank_d = ~mask_q[0];
          mask_d       = 4'd0;
        end
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!one_hot) state_d = ST_IDLE;
        else if (sel_s_q != smp_sel_q) start = 1'b1;
      end
    endcase

    if (start) begin
      smp_sel_d = sel_s_q;
      smp_seg_d = seg_s_q;
      cnt_d     = 3'd1;
      state_d   = (STABLE_W == 3'd1) ? ST_CAPTURE : ST_TRACK;
    end

    if (pend_q) begin
      dig_hh_d = pend_blank_q ? 2'd0 : hh_sh_q;
      dig_h_d  = h_sh_q;
      dig_mm_d = mm_sh_q;
      dig_m_d  = m_sh_q;
      blank_d  = pend_blank_q;
      fv_d     = 1'b1;
    end
  end

  // NOTE: state updates use <= so every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_m_q <= '0;  sel_s_q <= '0;  seg_m_q <= '1;  seg_s_q <= '1;
      state_q <= ST_IDLE;  cnt_q <= '0;  smp_sel_q <= '0;  smp_seg_q <= '1;
      // NOTE: shadow digits are reset too, so a frame never exposes power-up garbage.
      hh_sh_q <= '0;  h_sh_q <= '0;  mm_sh_q <= '0;  m_sh_q <= '0;
      mask_q <= '0;  err_q <= 1'b0;  to_q <= '0;  lost_q <= 1'b0;
      pend_q <= 1'b0;  pend_blank_q <= 1'b1;
      dig_hh_q <= '0;  dig_h_q <= '0;  dig_mm_q <= '0;  dig_m_q <= '0;
      blank_q <= 1'b1;  fv_q <= 1'b0;
    end else begin
      sel_m_q <= disp.dig_sel;  sel_s_q <= sel_m_q;
      seg_m_q <= disp.segs;     seg_s_q <= seg_m_q;
      state_q <= state_d;  cnt_q <= cnt_d;  smp_sel_q <= smp_sel_d;  smp_seg_q <= smp_seg_d;
      hh_sh_q <= hh_sh_d;  h_sh_q <= h_sh_d;  mm_sh_q <= mm_sh_d;  m_sh_q <= m_sh_d;
      mask_q <= mask_d;  err_q <= err_d;  to_q <= to_d;  lost_q <= lost_d;
      pend_q <= pend_d;  pend_blank_q <= pend_blank_d;
      dig_hh_q <= dig_hh_d;  dig_h_q <= dig_h_d;  dig_mm_q <= dig_mm_d;  dig_m_q <= dig_m_d;
      blank_q <= blank_d;  fv_q <= fv_d;
    end
  end

  assign dig_hh_o      = dig_hh_q;
  assign dig_h_o       = dig_h_q;
  assign dig_mm_o      = dig_mm_q;
  assign dig_m_o       = dig_m_q;
  assign hh_blank_o    = blank_q;
  assign frame_valid_o = fv_q;
  assign seg_error_o   = err_q;
  assign lost_o        = lost_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench: drives display scans, queues the frames each scan should publish
// and compares them as frame_valid pulses appear.
module tb_seg7_scan_decoder;

  typedef struct packed {
    logic       blank;
    logic [1:0] hh;
    logic [3:0] h;
    logic [2:0] mm;
    logic [3:0] m;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] dig_hh;
  logic [3:0] dig_h;
  logic [2:0] dig_mm;
  logic [3:0] dig_m;
  logic hh_blank, frame_valid, seg_error, lost;

  seg7_scan_decoder_if disp ();

  seg7_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut (
    .clk           (clk),
    .rst           (rst),
    .disp          (disp),
    .dig_hh_o      (dig_hh),
    .dig_h_o       (dig_h),
    .dig_mm_o      (dig_mm),
    .dig_m_o       (dig_m),
    .hh_blank_o    (hh_blank),
    .frame_valid_o (frame_valid),
    .seg_error_o   (seg_error),
    .lost_o        (lost)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_frames = 0;
  frame_t sb[$];
  int fv_times[$];
  logic [6:0] seg_tbl [10];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard side: every published frame must match the oldest queued expectation.
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_times.push_back(cyc);
      check("frame_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        frame_t e;
        e = sb.pop_front();
        check("frame", 32'({hh_blank, dig_hh, dig_h, dig_mm, dig_m}), 32'(e));
      end
    end
  end

  function automatic frame_t cur_out();
    return {hh_blank, dig_hh, dig_h, dig_mm, dig_m};
  endfunction

  task automatic expect_frame(input logic blank, input logic [1:0] hh, input logic [3:0] h,
                              input logic [2:0] mm, input logic [3:0] m);
    sb.push_back({blank, hh, h, mm, m});
    exp_frames++;
  endtask

  // One 32-cycle slot: strobe for on_cyc cycles (0 = suppressed), dark for the rest.
  task automatic drive_slot(input int slot, input logic [6:0] pat, input int on_cyc);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i < on_cyc) begin
        disp.dig_sel = 4'(1 << slot);
        disp.segs    = ~pat;
      end else begin
        disp.dig_sel = 4'd0;
        disp.segs    = 7'h7F;
      end
    end
  endtask

  task automatic scan(input int d0, input int d1, input int d2, input int d3, input bit show0);
    drive_slot(0, seg_tbl[d0], show0 ? 8 : 0);
    drive_slot(1, seg_tbl[d1], 8);
    drive_slot(2, seg_tbl[d2], 8);
    drive_slot(3, seg_tbl[d3], 8);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      disp.dig_sel = 4'd0;
      disp.segs    = 7'h7F;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dig"}, 32'({dig_hh, dig_h, dig_mm, dig_m}), 32'd0);
    check({tag, "_blank"}, 32'(hh_blank), 32'd1);
    check({tag, "_fv"}, 32'(frame_valid), 32'd0);
    check({tag, "_err"}, 32'(seg_error), 32'd0);
    check({tag, "_lost"}, 32'(lost), 32'd0);
  endtask

  initial begin
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    rst = 1'b1;
    disp.dig_sel = 4'd0;
    disp.segs    = 7'h7F;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Continuous 12:34 scan: one frame per 128 cycles.
    for (int f = 0; f < 3; f++) begin
      expect_frame(1'b0, 2'd1, 4'd2, 3'd3, 4'd4);
      scan(1, 2, 3, 4, 1'b1);
    end
    idle(16);
    check("frames_1234", 32'(fv_times.size()), 32'(exp_frames));
    check("period_a", 32'(fv_times[1] - fv_times[0]), 32'd128);
    check("period_b", 32'(fv_times[2] - fv_times[1]), 32'd128);
    check("err_clean", 32'(seg_error), 32'd0);

    // 09:59 with hour tens never strobed.
    expect_frame(1'b1, 2'd0, 4'd9, 3'd5, 4'd9);
    scan(0, 9, 5, 9, 1'b0);
    idle(16);
    check("frames_blank", 32'(fv_times.size()), 32'(exp_frames));

    // Slot 2 strobed one cycle short of stable: frame must be dropped.
    drive_slot(0, seg_tbl[1], 8);
    drive_slot(1, seg_tbl[2], 8);
    drive_slot(2, seg_tbl[3], 3);
    drive_slot(3, seg_tbl[4], 8);
    idle(16);
    check("frames_short", 32'(fv_times.size()), 32'(exp_frames));

    // Multi-hot strobes are ignored, so a lone slot 3 afterwards cannot complete a frame.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      disp.dig_sel = 4'b0110;
      disp.segs    = ~seg_tbl[8];
    end
    idle(22);
    drive_slot(3, seg_tbl[7], 8);
    idle(16);
    check("frames_multihot", 32'(fv_times.size()), 32'(exp_frames));
    check("err_multihot", 32'(seg_error), 32'd0);
    check("dig_after_multihot", 32'(cur_out()), 32'({1'b1, 2'd0, 4'd9, 3'd5, 4'd9}));

    // Illegal pattern on minute units.
    expect_frame(1'b0, 2'd1, 4'd2, 3'd3, 4'hF);
    drive_slot(0, seg_tbl[1], 8);
    drive_slot(1, seg_tbl[2], 8);
    drive_slot(2, seg_tbl[3], 8);
    drive_slot(3, 7'h49, 8);
    check("err_set", 32'(seg_error), 32'd1);

    // Silence: lost rises only after the timeout, published digits hold.
    idle(900);
    check("lost_early", 32'(lost), 32'd0);
    idle(200);
    check("lost_set", 32'(lost), 32'd1);
    check("dig_hold", 32'(cur_out()), 32'({1'b0, 2'd1, 4'd2, 3'd3, 4'hF}));

    expect_frame(1'b0, 2'd2, 4'd3, 3'd4, 4'd5);
    drive_slot(0, seg_tbl[2], 8);
    check("lost_clear", 32'(lost), 32'd0);
    drive_slot(1, seg_tbl[3], 8);
    drive_slot(2, seg_tbl[4], 8);
    drive_slot(3, seg_tbl[5], 8);
    check("err_sticky", 32'(seg_error), 32'd1);

    // Reset in the middle of a frame.
    drive_slot(0, seg_tbl[1], 8);
    drive_slot(1, seg_tbl[8], 8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    drive_slot(2, seg_tbl[0], 8);
    drive_slot(3, seg_tbl[6], 8);
    idle(16);
    check("frames_partial", 32'(fv_times.size()), 32'(exp_frames));

    expect_frame(1'b0, 2'd1, 4'd2, 3'd3, 4'd4);
    scan(1, 2, 3, 4, 1'b1);
    idle(20);
    check("frames_total", 32'(fv_times.size()), 32'(exp_frames));
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("err_after_rst", 32'(seg_error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
